uart_echo_fifo: RTL

Parametrised store-and-forward buffer between a UART receiver and a UART transmitter for echo/mirror designs on the iCE board. Received bytes go into a circular buffer with true full/empty tracking, overflow drop accounting, flush and pause. A read FSM drains the buffer to the transmitter under a ready/valid-pulse handshake. Sits between uart_rx (rx_dv/rx_byte) and uart_tx2 (tx_dv/tx_byte/ready) in the top level.

---
 rtl/uart_echo_fifo.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_echo_fifo.sv
// Store-and-forward echo buffer between uart_rx and uart_tx2: circular RAM, drop accounting, flush/pause.
// Optional LINE_BUFFER_EN: hold bytes until a full EOL-terminated line (or a full buffer) is present.
module uart_echo_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DROP_W = 16
`ifdef LINE_BUFFER_EN
    ,parameter logic [DATA_W-1:0] EOL_CHAR = DATA_W'(8'h0D)
`endif
) (
    input  logic              ICE_CLK,
    input  logic              ICE_RST,
    input  logic              rx_dv,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              tx_ready,
    output logic              tx_dv,
    output logic [DATA_W-1:0] tx_byte,
    input  logic              flush,
    input  logic              pause,
    input  logic              ovf_clr,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_HOLD, S_WAIT} state_e;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    state_e            state_q;
    logic              tx_dv_q;
    logic [DATA_W-1:0] tx_byte_q;

    logic wr_acc, drop, pop, line_ok, go;

    // Full is judged on the pre-edge flag; flush discards a coincident byte without counting it.
    assign wr_acc = rx_dv & ~full_q & ~flush;
    assign drop   = rx_dv &  full_q & ~flush;
    assign pop    = (state_q == S_SEND);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q + PTR_W'(wr_acc) - PTR_W'(pop);
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            drop_d     = ovf_clr ? DROP_W'(1) : ((&drop_q) ? drop_q : drop_q + DROP_W'(1));
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                  (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    end

    always_ff @(posedge ICE_CLK or posedge ICE_RST) begin
        if (ICE_RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Buffer RAM with registered read port; contents are never reset.
    always_ff @(posedge ICE_CLK) begin
        if (wr_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= rx_byte;
        if (state_q == S_READ) rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
    end

`ifdef LINE_BUFFER_EN
    logic [PTR_W-1:0] lines_q, lines_d;
    logic             eol_in, eol_out;

    assign eol_in  = wr_acc & (rx_byte == EOL_CHAR);
    assign eol_out = pop & (rd_data_q == EOL_CHAR);

    always_comb begin
        lines_d = lines_q + PTR_W'(eol_in) - PTR_W'(eol_out);
        if (flush) lines_d = '0;
    end

    always_ff @(posedge ICE_CLK or posedge ICE_RST) begin
        if (ICE_RST) lines_q <= '0;
        else         lines_q <= lines_d;
    end

    // A full buffer drains even without a terminator so the writer cannot deadlock.
    assign line_ok = (lines_q != '0) | full_q;
`else
    assign line_ok = 1'b1;
`endif

    assign go = ~empty_q & ~pause & tx_ready & ~flush & line_ok;

    // Read FSM: IDLE -> READ (RAM access) -> SEND (pulse) -> HOLD -> WAIT for transmitter.
    always_ff @(posedge ICE_CLK or posedge ICE_RST) begin
        if (ICE_RST) begin
            state_q   <= S_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            tx_dv_q <= 1'b0;
            case (state_q)
                S_IDLE: if (go) state_q <= S_READ;
                S_READ: state_q <= flush ? S_IDLE : S_SEND;
                S_SEND: begin
                    tx_byte_q <= rd_data_q;
                    tx_dv_q   <= 1'b1;
                    state_q   <= S_HOLD;
                end
                S_HOLD: state_q <= S_WAIT;
                S_WAIT: if (tx_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_dv      = tx_dv_q;
    assign tx_byte    = tx_byte_q;
    assign level      = level_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
endmodule
